alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
Sequencer and arbiter that shares the single combinational ALU between two requesters, for example the execute stage and a multi-cycle address/branch helper.
- Accepts operations over valid/ready handshakes and arbitrates round-robin.
- Drives the ALU from registered operands.
- Captures alu_o, cout and zero.
- Returns the result over a response handshake with backpressure.
- Rejects unsupported alu_ctrl codes with an error response.

Parameters:
- W, 8, operand/result width; must match the ALU's W.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  2  per-requester operation valid; bit i belongs to requester i.
- req_ready  out  2  per-requester accept; a transfer occurs when valid and ready are both high.
- req0_a, req0_b  in  W  requester 0 operands.
- req0_ctrl  in  4  requester 0 ALU op code.
- req1_a, req1_b  in  W  requester 1 operands.
- req1_ctrl  in  4  requester 1 ALU op code.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer accept.
- rsp_id  out  1  requester the response belongs to.
- rsp_o  out  W  captured alu_o.
- rsp_cout  out  1  captured cout.
- rsp_zero  out  1  captured zero.
- rsp_err  out  1  op code was illegal; the ALU was not used.
- alu_a, alu_b  out  W  to ALU a/b.
- alu_ctrl  out  4  to ALU alu_ctrl.
- alu_o  in  W  from ALU.
- cout  in  1  from ALU.
- zero  in  1  from ALU.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Legal op codes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR. Every other value is illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is high only in IDLE, and only for the granted requester. The grant is combinational from req_valid, so ready depends on valid.
  - Round-robin: if only one requester is valid, it is granted. If both are valid, the requester other than last_grant is granted.
  - On accept: latch operands, ctrl and id; set last_grant = id; check ctrl legality; go to EXEC.
- EXEC (exactly one cycle):
  - alu_a, alu_b and alu_ctrl are driven from the latched registers.
  - If illegal: alu_a = alu_b = 0 and alu_ctrl = 0.
  - At the cycle end, capture rsp_o/rsp_cout/rsp_zero from alu_o/cout/zero. If illegal, capture rsp_o = 0, rsp_cout = 0, rsp_zero = 0 and set rsp_err = 1.
  - Go to RESP.
- RESP:
  - rsp_valid = 1. All rsp_* outputs are stable until the handshake completes.
  - When rsp_ready is high, go to IDLE.
  - Incoming requests are held off (req_ready = 0) in EXEC and RESP.
- Latency: accept edge N; ALU driven during cycle N+1; rsp_valid high from cycle N+2. If rsp_ready is held high, one op completes every 3 cycles.
- Outside EXEC: alu_a, alu_b and alu_ctrl are driven from the latched registers (stable, no glitching to the ALU). They reset to 0.
- Reset values: state IDLE, last_grant = 1 (so requester 0 wins first contention), req_ready = 0 during reset, rsp_valid = 0, rsp_id = 0, rsp_o = 0, rsp_cout = 0, rsp_zero = 0, rsp_err = 0, busy = 0, all latches 0.
- Reset mid-operation (EXEC or RESP): the operation is discarded immediately and no response is produced; the FSM returns to IDLE.
- cout is meaningful only for ADD; it is captured as-is for all ops.
- A requester may drop req_valid before it is accepted; no state change results.
- rsp_ready is ignored outside RESP.

Decomposition:
- Shared package alu_pkg:
  - localparams ALU_AND = 4'd0, ALU_OR = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd6, ALU_SLT = 4'd7, ALU_NOR = 4'd12.
  - function alu_ctrl_legal.
  - typedef enum for FSM states {IDLE, EXEC, RESP}.
- One sub-module: rr_arb2. It takes the 2-bit req_valid and last_grant and produces a one-hot grant plus grant_id (combinational).

Test Plan:
1. Reset → all rsp_* = 0, busy = 0, alu_ctrl = 0. Then req_valid = 01 → req_ready = 01 in the same cycle.
2. Requester 0 ADD, a = 200, b = 100 → two cycles after accept: rsp_valid = 1, rsp_id = 0, rsp_o = 44, rsp_cout = 1, rsp_zero = 0, rsp_err = 0.
3. Both requesters valid for 3 consecutive ops (r0 SUB 5−5, r1 SLT 3<5, both continuously valid) → grant order r0, r1, r0. Responses: rsp_o = 0 with rsp_zero = 1; then rsp_o = 1 with rsp_zero = 0.
4. Backpressure: hold rsp_ready = 0 for 5 cycles after rsp_valid (op NOR 0x0F, 0xF0 → 0x00) → rsp_* stable and req_ready = 00 throughout; one cycle after rsp_ready = 1, state is IDLE.
5. Requester 1 with alu_ctrl = 5 → alu_ctrl driven 0 during EXEC; response rsp_err = 1, rsp_o = 0, rsp_id = 1.
6. Assert rst during EXEC of an AND op → rsp_valid stays 0, busy = 0 immediately. Then a new OR 0x0A, 0x50 completes with rsp_o = 0x5A.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU op codes, legality check and sequencer state encoding for alu_share_ctrl.
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'd0;
   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SUB = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;
   localparam logic [3:0] ALU_NOR = 4'd12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   function automatic logic alu_ctrl_legal(input logic [3:0] ctrl);
      logic legal;
      legal = 1'b0;
      case (ctrl)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: legal = 1'b1;
         default: legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; purely combinational, zero latency.
// On contention the requester that did not win last time is granted.
module rr_arb2 (
   input  logic [1:0] req_valid,
   input  logic       last_grant,
   output logic [1:0] grant,
   output logic       grant_id
);

   always_comb begin
      grant_id = 1'b0;
      grant    = 2'b00;
      case (req_valid)
         2'b01:   grant_id = 1'b0;
         2'b10:   grant_id = 1'b1;
         2'b11:   grant_id = ~last_grant;
         default: grant_id = 1'b0;
      endcase
      if (req_valid != 2'b00) begin
         grant = grant_id ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters; accept -> response in 2 cycles, 3 cycles/op.
// Backpressure: response held stable and all req_ready low until rsp_ready is seen in RESP.
module alu_share_ctrl
   import alu_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic [3:0]   req0_ctrl,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic [3:0]   req1_ctrl,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_o,
   output logic         rsp_cout,
   output logic         rsp_zero,
   output logic         rsp_err,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [3:0]   alu_ctrl,
   input  logic [W-1:0] alu_o,
   input  logic         cout,
   input  logic         zero,
   output logic         busy
);

   state_e       state_q, state_d;
   logic         last_grant_q, last_grant_d;
   logic         id_q, id_d;
   logic         err_q, err_d;
   logic [W-1:0] a_q, a_d;
   logic [W-1:0] b_q, b_d;
   logic [3:0]   ctrl_q, ctrl_d;
   logic         rsp_id_q, rsp_id_d;
   logic [W-1:0] rsp_o_q, rsp_o_d;
   logic         rsp_cout_q, rsp_cout_d;
   logic         rsp_zero_q, rsp_zero_d;
   logic         rsp_err_q, rsp_err_d;

   logic [1:0]   grant;
   logic         grant_id;
   logic         accept;
   logic         sel_legal;
   logic [W-1:0] sel_a;
   logic [W-1:0] sel_b;
   logic [3:0]   sel_ctrl;

   rr_arb2 u_arb (
      .req_valid  (req_valid),
      .last_grant (last_grant_q),
      .grant      (grant),
      .grant_id   (grant_id)
   );

   assign req_ready = (state_q == IDLE && !rst) ? grant : 2'b00;
   assign accept    = |(req_valid & req_ready);
   assign sel_a     = grant_id ? req1_a    : req0_a;
   assign sel_b     = grant_id ? req1_b    : req0_b;
   assign sel_ctrl  = grant_id ? req1_ctrl : req0_ctrl;
   assign sel_legal = alu_ctrl_legal(sel_ctrl);

   // Illegal ops latch zeros, so the ALU inputs are clean registers in every state.
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_ctrl  = ctrl_q;

   assign rsp_valid = (state_q == RESP);
   assign busy      = (state_q != IDLE);
   assign rsp_id    = rsp_id_q;
   assign rsp_o     = rsp_o_q;
   assign rsp_cout  = rsp_cout_q;
   assign rsp_zero  = rsp_zero_q;
   assign rsp_err   = rsp_err_q;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      err_d        = err_q;
      a_d          = a_q;
      b_d          = b_q;
      ctrl_d       = ctrl_q;
      rsp_id_d     = rsp_id_q;
      rsp_o_d      = rsp_o_q;
      rsp_cout_d   = rsp_cout_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               id_d         = grant_id;
               last_grant_d = grant_id;
               err_d        = ~sel_legal;
               a_d          = sel_legal ? sel_a    : '0;
               b_d          = sel_legal ? sel_b    : '0;
               ctrl_d       = sel_legal ? sel_ctrl : 4'd0;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            rsp_id_d   = id_q;
            rsp_o_d    = err_q ? '0   : alu_o;
            rsp_cout_d = err_q ? 1'b0 : cout;
            rsp_zero_d = err_q ? 1'b0 : zero;
            rsp_err_d  = err_q;
            state_d    = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         err_q        <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         ctrl_q       <= 4'd0;
         rsp_id_q     <= 1'b0;
         rsp_o_q      <= '0;
         rsp_cout_q   <= 1'b0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         err_q        <= err_d;
         a_q          <= a_d;
         b_q          <= b_d;
         ctrl_q       <= ctrl_d;
         rsp_id_q     <= rsp_id_d;
         rsp_o_q      <= rsp_o_d;
         rsp_cout_q   <= rsp_cout_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl with a behavioural ALU attached to the alu_* ports.
module tb_alu_share_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]   req0_ctrl, req1_ctrl;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_zero, rsp_err;
   logic [W-1:0] rsp_o;
   logic [W-1:0] alu_a, alu_b, alu_o;
   logic [3:0]   alu_ctrl;
   logic         cout, zero, busy;

   typedef struct packed {
      logic         id;
      logic [W-1:0] o;
      logic         cout;
      logic         zero;
      logic         err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   alu_share_ctrl #(.W(W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
      .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_o(rsp_o), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_o(alu_o), .cout(cout), .zero(zero), .busy(busy)
   );

   // Reference ALU: SUB carry is the carry out of a + ~b + 1.
   always_comb begin
      logic [W:0] s;
      s     = '0;
      alu_o = '0;
      cout  = 1'b0;
      case (alu_ctrl)
         4'd0:  alu_o = alu_a & alu_b;
         4'd1:  alu_o = alu_a | alu_b;
         4'd2:  begin s = {1'b0, alu_a} + {1'b0, alu_b}; alu_o = s[W-1:0]; cout = s[W]; end
         4'd6:  begin s = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1; alu_o = s[W-1:0]; cout = s[W]; end
         4'd7:  alu_o = (alu_a < alu_b) ? 8'd1 : 8'd0;
         4'd12: alu_o = ~(alu_a | alu_b);
         default: alu_o = '0;
      endcase
      zero = (alu_o == '0);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic id, input logic [W-1:0] o,
                               input logic c, input logic z, input logic e);
      exp_t x;
      x.id = id; x.o = o; x.cout = c; x.zero = z; x.err = e;
      return x;
   endfunction

   // Monitor: pops one expected response per completed response handshake.
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_o), 32'hDEAD);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_id",   32'(rsp_id),   32'(e.id));
            chk("rsp_o",    32'(rsp_o),    32'(e.o));
            chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
            chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
            chk("rsp_err",  32'(rsp_err),  32'(e.err));
         end
      end
   end

   task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] c);
      bit got;
      got = 1'b0;
      if (id) begin req1_a = a; req1_b = b; req1_ctrl = c; end
      else    begin req0_a = a; req0_b = b; req0_ctrl = c; end
      req_valid[id] = 1'b1;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (req_ready[id]) got = 1'b1;
      end
      if (!got) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 req_valid[id] = 1'b0;
   endtask

   task automatic wait_rsp_valid();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (rsp_valid) got = 1'b1;
      end
      if (!got) chk("rsp_valid_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      bit   done;
      int   accepts;
      logic exp_order[3];
      rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
      req0_a = '0; req0_b = '0; req0_ctrl = 4'd0;
      req1_a = '0; req1_b = '0; req1_ctrl = 4'd0;

      // 1: reset state, then combinational grant
      req_valid = 2'b01;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_bits",  32'({rsp_id, rsp_o, rsp_cout, rsp_zero, rsp_err}), 32'd0);
      chk("rst_busy",      32'(busy), 32'd0);
      chk("rst_alu_ctrl",  32'(alu_ctrl), 32'd0);
      req_valid = 2'b00;
      @(posedge clk); #1 rst = 1'b0;
      req0_a = 8'd200; req0_b = 8'd100; req0_ctrl = 4'd2;
      req_valid = 2'b01;
      #1 chk("ready_same_cycle", 32'(req_ready), 32'd1);

      // 2: ADD 200+100 wraps to 44 with carry
      exp_q.push_back(mk(1'b0, 8'd44, 1'b1, 1'b0, 1'b0));
      issue(1'b0, 8'd200, 8'd100, 4'd2);
      @(negedge clk);
      chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("exec_alu_a",     32'(alu_a), 32'd200);
      chk("exec_busy",      32'(busy), 32'd1);
      @(negedge clk);
      chk("n2_rsp_valid",   32'(rsp_valid), 32'd1);
      @(posedge clk); #1;

      // 5: illegal op from requester 1
      exp_q.push_back(mk(1'b1, 8'd0, 1'b0, 1'b0, 1'b1));
      issue(1'b1, 8'd7, 8'd9, 4'd5);
      @(negedge clk);
      chk("illegal_alu_ctrl", 32'(alu_ctrl), 32'd0);
      chk("illegal_alu_ab",   32'({alu_a, alu_b}), 32'd0);
      repeat (3) @(posedge clk); #1;

      // 3: contention, last_grant is now 1 so order is r0, r1, r0
      req0_a = 8'd5; req0_b = 8'd5; req0_ctrl = 4'd6;
      req1_a = 8'd3; req1_b = 8'd5; req1_ctrl = 4'd7;
      exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0;
      exp_q.push_back(mk(1'b0, 8'd0, 1'b1, 1'b1, 1'b0));
      exp_q.push_back(mk(1'b1, 8'd1, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(1'b0, 8'd0, 1'b1, 1'b1, 1'b0));
      req_valid = 2'b11;
      accepts = 0;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (req_ready != 2'b00) begin
            chk("rr_grant", 32'(req_ready), exp_order[accepts] ? 32'd2 : 32'd1);
            accepts++;
            if (accepts == 3) begin
               @(posedge clk); #1 req_valid = 2'b00;
               done = 1'b1;
            end
         end
      end
      if (!done) chk("rr_timeout", 32'(accepts), 32'd3);
      repeat (3) @(posedge clk); #1;

      // 4: backpressure on NOR response
      rsp_ready = 1'b0;
      exp_q.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0));
      issue(1'b0, 8'h0F, 8'hF0, 4'd12);
      req_valid[1] = 1'b1;
      wait_rsp_valid();
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_rsp_hold",  32'({rsp_id, rsp_o, rsp_cout, rsp_zero, rsp_err}), 32'h002);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_idle_busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk); #1;

      // 6: reset during EXEC discards the op
      issue(1'b0, 8'hFF, 8'h0F, 4'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_exec_busy",      32'(busy), 32'd0);
      chk("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      end
      @(posedge clk); #1;
      exp_q.push_back(mk(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0));
      issue(1'b0, 8'h0A, 8'h50, 4'd1);

      done = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(posedge clk);
         if (exp_q.size() == 0) done = 1'b1;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
